// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: command codes and FSM state encoding.
package md_pkg;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// The partial remainder always stays below the divisor, so it fits in WIDTH bits;
// only the shifted value needs one extra bit before the trial subtraction.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0]   w_shift;
    logic             w_lt;
    logic [WIDTH-1:0] w_sub;

    assign w_shift = {i_r, i_q[WIDTH-1]};
    assign w_lt    = w_shift < {1'b0, i_d};
    // Only used when w_shift >= divisor, where the true difference is below 2^WIDTH
    assign w_sub   = w_shift[WIDTH-1:0] - i_d;

    assign o_r = w_lt ? w_shift[WIDTH-1:0] : w_sub;
    assign o_q = {i_q[WIDTH-2:0], ~w_lt};

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, sign-corrected) unit
// writing the HI/LO pair. One iteration per clock, WIDTH iterations, then a commit edge.
//
// state | meaning
// IDLE  | waiting for a command; hi/lo hold
// MULT  | Booth iterations, commit product on the edge after the last step
// DIV   | restoring iterations, commit quotient/remainder on the edge after the last step
// DONE  | one-cycle result strobe (done, and div0 for divide-by-zero)
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mult_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        r_state;
    md_state_t        w_state_next;
    logic [CW-1:0]    r_cnt;
    // Booth upper half carries one guard bit so that subtracting the most-negative
    // multiplicand cannot overflow; in divide mode only the low WIDTH bits are used.
    logic [WIDTH:0]   r_a;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [WIDTH-1:0] r_m;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_div0;

    logic             w_last;
    logic             w_div0_start;
    logic [WIDTH:0]   w_m_ext;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_div_r;
    logic [WIDTH-1:0] w_div_q;

    assign w_last       = (r_cnt == CW'(WIDTH));
    assign w_div0_start = (r_state == ST_IDLE) && (mult_div == MD_DIV) && (op_b == '0);
    // Most-negative operand maps to itself, which reads correctly as an unsigned magnitude
    assign w_abs_a      = op_a[WIDTH-1] ? -op_a : op_a;
    assign w_abs_b      = op_b[WIDTH-1] ? -op_b : op_b;
    assign w_m_ext      = {r_m[WIDTH-1], r_m};

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_r (r_a[WIDTH-1:0]),
        .i_q (r_q),
        .i_d (r_m),
        .o_r (w_div_r),
        .o_q (w_div_q)
    );

    // Booth add/subtract selected by the current multiplier bit pair
    always_comb begin
        w_booth_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_a + w_m_ext;
            2'b10:   w_booth_sum = r_a - w_m_ext;
            default: w_booth_sum = r_a;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mult_div == MD_MULT)     w_state_next = ST_MULT;
                else if (mult_div == MD_DIV) w_state_next = (op_b == '0) ? ST_DONE : ST_DIV;
            end
            ST_MULT: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DIV: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand capture, per-cycle iteration and the single HI/LO commit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_m     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div0  <= 1'b0;
        end else begin
            r_div0 <= w_div0_start;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (mult_div == MD_MULT) begin
                        r_a   <= '0;
                        r_q   <= op_b;
                        r_qm1 <= 1'b0;
                        r_m   <= op_a;
                    end else if (mult_div == MD_DIV && op_b != '0) begin
                        r_a     <= '0;
                        r_q     <= w_abs_a;
                        r_m     <= w_abs_b;
                        r_neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        r_neg_r <= op_a[WIDTH-1];
                    end
                end
                ST_MULT: begin
                    if (w_last) begin
                        r_hi <= r_a[WIDTH-1:0];
                        r_lo <= r_q;
                    end else begin
                        r_a   <= {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                        r_q   <= {w_booth_sum[0], r_q[WIDTH-1:1]};
                        r_qm1 <= r_q[0];
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DIV: begin
                    if (w_last) begin
                        r_lo <= r_neg_q ? -r_q : r_q;
                        r_hi <= r_neg_r ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
                    end else begin
                        r_a   <= {1'b0, w_div_r};
                        r_q   <= w_div_q;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign div0 = r_div0;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed products, quotients and remainders,
// latency, busy/done/div0 behaviour, ignored commands and mid-operation reset.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clock;
    logic        reset;
    logic [1:0]  mult_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;

    int n_pass  = 0;
    int n_total = 0;

    int lat;
    int busy_cnt;
    logic first_busy;
    logic div0_at_done;
    int done_after_reset;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .mult_div (mult_div),
        .op_a     (op_a),
        .op_b     (op_b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div0     (div0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // lat counts edges after the sampling edge until done is first seen (0 = on the sampling edge).
    // An optional second command is driven for one cycle after edge inj_at.
    task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input int inj_at, input logic [1:0] inj_cmd,
                          input logic [31:0] inj_a, input logic [31:0] inj_b);
        mult_div = cmd;
        op_a     = a;
        op_b     = b;
        tick();
        mult_div   = MD_NONE;
        lat        = 0;
        busy_cnt   = 0;
        first_busy = busy;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (lat == inj_at) begin
                mult_div = inj_cmd;
                op_a     = inj_a;
                op_b     = inj_b;
            end else begin
                mult_div = MD_NONE;
            end
            tick();
            lat++;
        end
        mult_div     = MD_NONE;
        div0_at_done = div0;
    endtask

    initial begin
        reset    = 1'b1;
        mult_div = MD_NONE;
        op_a     = '0;
        op_b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_hi",   hi,   32'h0);
        check("rst_lo",   lo,   32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_div0", {31'b0, div0}, 32'h0);

        // 7 * -3 = -21
        run_op(MD_MULT, 32'd7, 32'hFFFF_FFFD, -1, MD_NONE, '0, '0);
        check("m1_busy_start", {31'b0, first_busy}, 32'h1);
        check("m1_lat", lat, 33);
        check("m1_hi", hi, 32'hFFFF_FFFF);
        check("m1_lo", lo, 32'hFFFF_FFEB);
        check("m1_div0", {31'b0, div0_at_done}, 32'h0);
        tick();
        check("m1_done_pulse", {31'b0, done}, 32'h0);
        check("m1_busy_after", {31'b0, busy}, 32'h0);

        // (-2^31)^2 = 2^62
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, -1, MD_NONE, '0, '0);
        check("m2_hi", hi, 32'h4000_0000);
        check("m2_lo", lo, 32'h0000_0000);
        tick();

        // (2^31-1)^2 = 0x3FFFFFFF_00000001
        run_op(MD_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1, MD_NONE, '0, '0);
        check("m3_hi", hi, 32'h3FFF_FFFF);
        check("m3_lo", lo, 32'h0000_0001);
        tick();

        // -7 / 2 = -3 rem -1
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, MD_NONE, '0, '0);
        check("d1_lat", lat, 33);
        check("d1_lo", lo, 32'hFFFF_FFFD);
        check("d1_hi", hi, 32'hFFFF_FFFF);
        tick();

        // -100 / -7 = 14 rem -2
        run_op(MD_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, MD_NONE, '0, '0);
        check("d2_lo", lo, 32'h0000_000E);
        check("d2_hi", hi, 32'hFFFF_FFFE);
        tick();

        // Preload hi=5, lo=9 with 95 / 10
        run_op(MD_DIV, 32'd95, 32'd10, -1, MD_NONE, '0, '0);
        check("pre_lo", lo, 32'd9);
        check("pre_hi", hi, 32'd5);
        tick();

        // Divide by zero: done and div0 right after the sampling edge, no busy, hi/lo kept
        run_op(MD_DIV, 32'd1234, 32'd0, -1, MD_NONE, '0, '0);
        check("dz_lat",  lat, 0);
        check("dz_div0", {31'b0, div0_at_done}, 32'h1);
        check("dz_busy", {31'b0, busy}, 32'h0);
        check("dz_busy_cnt", busy_cnt, 0);
        check("dz_hi", hi, 32'd5);
        check("dz_lo", lo, 32'd9);
        tick();
        check("dz_done_pulse", {31'b0, done}, 32'h0);
        check("dz_div0_pulse", {31'b0, div0}, 32'h0);

        // Overflow divide wraps, no flag
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, MD_NONE, '0, '0);
        check("ov_lo", lo, 32'h8000_0000);
        check("ov_hi", hi, 32'h0000_0000);
        check("ov_div0", {31'b0, div0_at_done}, 32'h0);
        tick();

        // Mult command during a divide is ignored: 100 / 7 = 14 rem 2
        run_op(MD_DIV, 32'd100, 32'd7, 10, MD_MULT, 32'd3, 32'd3);
        check("ig_lat", lat, 33);
        check("ig_lo", lo, 32'd14);
        check("ig_hi", hi, 32'd2);
        tick();
        check("ig_idle_busy", {31'b0, busy}, 32'h0);

        // Reset during a multiply
        mult_div = MD_MULT;
        op_a     = 32'd3;
        op_b     = 32'd5;
        tick();
        mult_div = MD_NONE;
        for (int i = 0; i < 15; i++) tick();
        check("rm_busy_before", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rm_hi",   hi, 32'h0);
        check("rm_lo",   lo, 32'h0);
        check("rm_busy", {31'b0, busy}, 32'h0);
        check("rm_done", {31'b0, done}, 32'h0);
        done_after_reset = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_after_reset++;
        end
        check("rm_no_done", done_after_reset, 0);
        check("rm_hi_hold", hi, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
